// File: rtl/hpf_pkg.sv
// hpf_pkg: shared constants and FSM state type for the HPF serial transmitter.
// Frame width is chosen in hpf_serial_tx under the HPF_TX_PARITY_EN macro.
package hpf_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_GAP_CYCLES = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/hpf_sample_fifo.sv
// hpf_sample_fifo: single-clock sample FIFO; pointers carry an extra wrap bit for full/empty.
// A push while full is accepted when a pop happens in the same cycle.
module hpf_sample_fifo
  import hpf_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = SAMPLE_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rptr[AW-1:0]];
  assign o_level   = r_wptr - r_rptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers make stale contents unreachable.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/hpf_serial_tx.sv
// hpf_serial_tx: captures filtered HPF samples into a FIFO and shifts them to the MCU (SPI mode 0, MSB first).
// Define HPF_TX_PARITY_EN to append an even-parity bit after bit0 of every frame.
module hpf_serial_tx
  import hpf_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                        M_CLK,
  input  logic                        M_RST_N,
  input  logic                        DATA_READY,
  input  logic [SAMPLE_W-1:0]         HPF_IN,
  input  logic                        OVF_CLR,
  output logic                        SCLK,
  output logic                        SDO,
  output logic                        CS_N,
  output logic                        OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);

`ifdef HPF_TX_PARITY_EN
  localparam int FRAME_W = SAMPLE_W + 1;
`else
  localparam int FRAME_W = SAMPLE_W;
`endif
  localparam int                 LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0]        DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0]        GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [4:0]         BIT_LAST = 5'(FRAME_W - 1);

  logic                r_dr_s1;
  logic                r_dr_s2;
  logic                r_dr_s3;
  logic                r_push;
  logic [SAMPLE_W-1:0] r_hold;
  logic                r_ovf;
  tx_state_e           r_state;
  tx_state_e           w_next;
  logic [15:0]         r_cnt;
  logic [4:0]          r_bits;
  logic                r_sclk;
  logic [FRAME_W-1:0]  r_shift;

  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_drop;
  logic                w_tick;
  logic                w_last;
  logic [SAMPLE_W-1:0] w_head;
  logic [FRAME_W-1:0]  w_frame;
  logic [LVL_W-1:0]    w_level;

  // The registered edge pulse lands the push three edges after DATA_READY is first sampled;
  // r_hold keeps the sample because the strobe may already be low by then.
  always_ff @(posedge M_CLK or negedge M_RST_N) begin
    if (!M_RST_N) begin
      r_dr_s1 <= 1'b0;
      r_dr_s2 <= 1'b0;
      r_dr_s3 <= 1'b0;
      r_push  <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_dr_s1 <= DATA_READY;
      r_dr_s2 <= r_dr_s1;
      r_dr_s3 <= r_dr_s2;
      r_push  <= r_dr_s2 & ~r_dr_s3;
      if (DATA_READY) r_hold <= HPF_IN;
    end
  end

  hpf_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .i_clk   (M_CLK),
    .i_rst_n (M_RST_N),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_data  (r_hold),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_drop = r_push & w_full & ~w_pop;

  always_ff @(posedge M_CLK or negedge M_RST_N) begin
    if (!M_RST_N) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (OVF_CLR) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef HPF_TX_PARITY_EN
  assign w_frame = {w_head, ^w_head};
`else
  assign w_frame = w_head;
`endif

  always_ff @(posedge M_CLK or negedge M_RST_N) begin
    if (!M_RST_N) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  assign w_tick = (r_cnt == DIV_LAST);
  assign w_last = w_tick & r_sclk & (r_bits == BIT_LAST);

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_next = ST_LOAD;
      ST_LOAD: begin
        w_pop  = 1'b1;
        w_next = ST_SHIFT;
      end
      ST_SHIFT: if (w_last) w_next = ST_GAP;
      ST_GAP:   if (r_cnt == GAP_LAST) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // SCLK toggles every CLK_DIV cycles; the register shifts on falling toggles so SDO
  // changes while SCLK is low and holds steady through each rising edge.
  always_ff @(posedge M_CLK or negedge M_RST_N) begin
    if (!M_RST_N) begin
      r_cnt   <= '0;
      r_bits  <= '0;
      r_sclk  <= 1'b0;
      r_shift <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_shift <= w_frame;
          r_cnt   <= '0;
          r_bits  <= '0;
          r_sclk  <= 1'b0;
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (w_last) begin
              r_sclk  <= 1'b0;
              r_bits  <= '0;
              r_shift <= '0;
            end else begin
              r_sclk <= ~r_sclk;
              if (r_sclk) begin
                r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                r_bits  <= r_bits + 5'd1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          r_cnt <= r_cnt + 16'd1;
        end
        default: begin
          r_cnt  <= '0;
          r_sclk <= 1'b0;
        end
      endcase
    end
  end

  assign SCLK       = r_sclk;
  assign CS_N       = ~((r_state == ST_LOAD) | (r_state == ST_SHIFT));
  assign SDO        = (r_state == ST_LOAD)  ? w_frame[FRAME_W-1] :
                      (r_state == ST_SHIFT) ? r_shift[FRAME_W-1] : 1'b0;
  assign OVERFLOW   = r_ovf;
  assign FIFO_LEVEL = w_level;

endmodule

// File: tb/tb_hpf_serial_tx.sv
// tb_hpf_serial_tx: scoreboard bench for hpf_serial_tx (CLK_DIV=4, FIFO_DEPTH=4, GAP_CYCLES=8).
// Define HPF_TX_PARITY_EN for the bench as well as the RTL to expect 17-bit frames.
module tb_hpf_serial_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_CYCLES = 8;
`ifdef HPF_TX_PARITY_EN
  localparam int FRAME_W = 17;
`else
  localparam int FRAME_W = 16;
`endif
  localparam int LOW_CYCLES = 1 + 2 * FRAME_W * CLK_DIV;

  logic        M_CLK      = 1'b0;
  logic        M_RST_N    = 1'b0;
  logic        DATA_READY = 1'b0;
  logic [15:0] HPF_IN     = 16'h0000;
  logic        OVF_CLR    = 1'b0;
  logic        SCLK;
  logic        SDO;
  logic        CS_N;
  logic        OVERFLOW;
  logic [2:0]  FIFO_LEVEL;

  int          total      = 0;
  int          bad        = 0;
  int          framesSeen = 0;
  logic [15:0] expQ[$];
  bit          trackPeak  = 1'b0;
  int          peakLevel  = 0;

  logic        prevCs    = 1'b1;
  logic        prevSclk  = 1'b0;
  logic [16:0] capBits   = '0;
  int          bitCnt    = 0;
  int          gapCnt    = 0;
  bit          haveFrame = 1'b0;

  logic [15:0] burstData [5] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F};

  hpf_serial_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .M_CLK      (M_CLK),
    .M_RST_N    (M_RST_N),
    .DATA_READY (DATA_READY),
    .HPF_IN     (HPF_IN),
    .OVF_CLR    (OVF_CLR),
    .SCLK       (SCLK),
    .SDO        (SDO),
    .CS_N       (CS_N),
    .OVERFLOW   (OVERFLOW),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  always #5 M_CLK = ~M_CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one strobe held high for two clock edges; the expected frame is queued at the same time.
  task automatic applyStimulus(input logic [15:0] sample, input bit expectFrame);
    HPF_IN     = sample;
    DATA_READY = 1'b1;
    if (expectFrame) expQ.push_back(sample);
    repeat (2) @(negedge M_CLK);
    DATA_READY = 1'b0;
  endtask

  task automatic waitForCs(input logic level, input int maxCycles, input string tag);
    int n = 0;
    while (CS_N !== level && n < maxCycles) begin
      @(negedge M_CLK);
      n++;
    end
    checkOutput(tag, 32'(CS_N), 32'(level));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((expQ.size() != 0 || FIFO_LEVEL != 3'd0 || CS_N !== 1'b1) && n < 3000) begin
      @(negedge M_CLK);
      n++;
    end
    checkOutput(tag, 32'(expQ.size()), 0);
  endtask

  always @(negedge M_CLK) begin
    if (!trackPeak) peakLevel = 0;
    else if (int'(FIFO_LEVEL) > peakLevel) peakLevel = int'(FIFO_LEVEL);
  end

  // Frame monitor: samples SDO on each SCLK rise inside a frame and scores the frame when CS_N rises.
  always @(negedge M_CLK) begin
    logic [15:0] d;
    logic [16:0] e;
    if (!M_RST_N) begin
      prevCs    = 1'b1;
      prevSclk  = 1'b0;
      capBits   = '0;
      bitCnt    = 0;
      gapCnt    = 0;
      haveFrame = 1'b0;
    end else begin
      if (prevCs && !CS_N) begin
        if (haveFrame) checkOutput("cs_gap_min", 32'(gapCnt >= GAP_CYCLES + 1), 1);
        capBits = '0;
        bitCnt  = 0;
      end
      if (!CS_N && SCLK && !prevSclk) begin
        capBits = {capBits[15:0], SDO};
        bitCnt++;
      end
      if (!prevCs && CS_N) begin
        framesSeen++;
        haveFrame = 1'b1;
        gapCnt    = 0;
        checkOutput("frame_bits", bitCnt, FRAME_W);
        checkOutput("frame_expected", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          d = expQ.pop_front();
`ifdef HPF_TX_PARITY_EN
          e = {d, ^d};
`else
          e = {1'b0, d};
`endif
          checkOutput("frame_data", 32'(capBits), 32'(e));
        end
      end
      if (CS_N) gapCnt++;
      prevCs   = CS_N;
      prevSclk = SCLK;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lowCnt;
    int rises;
    int guard;
    logic prevS;

    repeat (3) @(negedge M_CLK);
    checkOutput("rst_sclk", 32'(SCLK), 0);
    checkOutput("rst_sdo", 32'(SDO), 0);
    checkOutput("rst_cs_n", 32'(CS_N), 1);
    checkOutput("rst_overflow", 32'(OVERFLOW), 0);
    checkOutput("rst_level", 32'(FIFO_LEVEL), 0);
    M_RST_N = 1'b1;
    repeat (2) @(negedge M_CLK);
    checkOutput("idle_cs_n", 32'(CS_N), 1);

    $display("[TB] single sample 16'hA53C");
    applyStimulus(16'hA53C, 1'b1);
    @(negedge M_CLK);
    checkOutput("lat_level_k2", 32'(FIFO_LEVEL), 0);
    @(negedge M_CLK);
    checkOutput("lat_level_k3", 32'(FIFO_LEVEL), 1);
    checkOutput("lat_cs_k3", 32'(CS_N), 1);
    @(negedge M_CLK);
    checkOutput("lat_cs_k4", 32'(CS_N), 0);
    checkOutput("load_sdo_msb", 32'(SDO), 1);
    lowCnt = 1;
    while (CS_N === 1'b0 && lowCnt < 400) begin
      @(negedge M_CLK);
      if (CS_N === 1'b0) lowCnt++;
    end
    checkOutput("frame_low_cycles", lowCnt, LOW_CYCLES);
    drain("drain_single");

    $display("[TB] burst of 5 behind a frame in flight");
    applyStimulus(16'h3C3C, 1'b1);
    waitForCs(1'b0, 50, "lead_cs_low");
    trackPeak = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(burstData[i], i < 4);
      repeat (8) @(negedge M_CLK);
      if (i == 3) begin
        checkOutput("burst_ovf_before", 32'(OVERFLOW), 0);
        checkOutput("burst_level4", 32'(FIFO_LEVEL), 4);
      end
      if (i == 4) begin
        checkOutput("burst_ovf_set", 32'(OVERFLOW), 1);
        checkOutput("burst_level_hold", 32'(FIFO_LEVEL), 4);
      end
    end
    checkOutput("burst_peak", peakLevel, 4);
    trackPeak = 1'b0;

    $display("[TB] overflow versus clear");
    OVF_CLR = 1'b1;
    @(negedge M_CLK);
    OVF_CLR = 1'b0;
    checkOutput("ovf_lone_clr", 32'(OVERFLOW), 0);
    applyStimulus(16'hBEEF, 1'b0);
    @(negedge M_CLK);
    OVF_CLR = 1'b1;
    @(negedge M_CLK);
    OVF_CLR = 1'b0;
    checkOutput("ovf_set_wins", 32'(OVERFLOW), 1);
    checkOutput("ovf_level_full", 32'(FIFO_LEVEL), 4);
    @(negedge M_CLK);
    OVF_CLR = 1'b1;
    @(negedge M_CLK);
    OVF_CLR = 1'b0;
    checkOutput("ovf_clr_later", 32'(OVERFLOW), 0);

    $display("[TB] push into a full FIFO during the LOAD pop");
    waitForCs(1'b1, 300, "lead_frame_end");
    repeat (GAP_CYCLES - 2) @(negedge M_CLK);
    applyStimulus(16'h7E81, 1'b1);
    @(negedge M_CLK);
    checkOutput("pop_cycle_cs", 32'(CS_N), 0);
    checkOutput("pop_cycle_level", 32'(FIFO_LEVEL), 4);
    @(negedge M_CLK);
    checkOutput("push_pop_level", 32'(FIFO_LEVEL), 4);
    checkOutput("push_pop_no_ovf", 32'(OVERFLOW), 0);
    drain("drain_burst");
    checkOutput("frames_seen", framesSeen, 7);

    $display("[TB] parity corner samples");
    applyStimulus(16'h0001, 1'b1);
    drain("drain_p1");
    applyStimulus(16'h0003, 1'b1);
    drain("drain_p3");
    checkOutput("frames_seen_all", framesSeen, 9);

    $display("[TB] reset mid-frame");
    applyStimulus(16'hFFFF, 1'b0);
    waitForCs(1'b0, 50, "rst_frame_start");
    rises = 0;
    guard = 0;
    prevS = SCLK;
    while (rises < 7 && guard < 400) begin
      @(negedge M_CLK);
      if (SCLK && !prevS) rises++;
      prevS = SCLK;
      guard++;
    end
    repeat (2) @(negedge M_CLK);
    checkOutput("pre_rst_sclk", 32'(SCLK), 1);
    checkOutput("pre_rst_sdo", 32'(SDO), 1);
    M_RST_N = 1'b0;
    #1;
    checkOutput("rst_async_cs", 32'(CS_N), 1);
    checkOutput("rst_async_sclk", 32'(SCLK), 0);
    checkOutput("rst_async_sdo", 32'(SDO), 0);
    repeat (3) @(negedge M_CLK);
    M_RST_N = 1'b1;
    @(negedge M_CLK);
    checkOutput("post_rst_level", 32'(FIFO_LEVEL), 0);
    lowCnt = 0;
    repeat (40) begin
      @(negedge M_CLK);
      if (CS_N !== 1'b1) lowCnt++;
    end
    checkOutput("post_rst_no_frame", lowCnt, 0);
    checkOutput("queue_empty_end", 32'(expQ.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
